pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_stage_reg_if.sv | 25 ++
 rtl/pipe_slot.sv | 37 +++
 rtl/pipe_stage_reg.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared state encoding, control-bit positions and counter width for the
// pipeline stage register and its storage slots.
package pipe_pkg;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_HALF  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    // Encoding equals the number of held entries, so occupancy is the state.
    typedef enum logic [1:0] {
        EMPTY = S_EMPTY,
        HALF  = S_HALF,
        FULL  = S_FULL
    } state_e;

    localparam int CTRL_MEMREAD  = 0;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_REGWRITE = 2;
    localparam int CTRL_J        = 3;
    localparam int CTRL_BR       = 4;

    localparam int STALL_W = 16;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for the upstream and downstream sides of a
// pipeline stage; master is the traffic source/sink, slave is the stage.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_slot.sv
// One stored entry: control bits cleared on reset/clear, payload load-only.
module pipe_slot #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic              i_clr,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (!reset_n || i_clr) begin
            r_ctrl <= '0;
        end else if (i_load) begin
            r_ctrl <= i_ctrl;
        end
    end

    // Payload has no reset: the ctrl bits alone decide whether it matters.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_ctrl = r_ctrl;
    assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional two-entry skid buffer, flush squash
// and a saturating downstream-stall counter.
//
// state | meaning
// EMPTY | nothing held, output invalid
// HALF  | main slot holds the head entry
// FULL  | main holds head, skid holds the next entry; upstream blocked
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 5,
    parameter bit SKID   = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    pipe_stage_reg_if.slave    bus,
    output logic [1:0]         occupancy,
    output logic [STALL_W-1:0] stall_cnt
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic               r_in_ready;
    logic [STALL_W-1:0] r_stall_cnt;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_consume;
    logic               w_main_load;
    logic               w_skid_load;
    logic               w_main_from_skid;
    logic [CTRL_W-1:0]  w_main_ctrl;
    logic [CTRL_W-1:0]  w_skid_ctrl;
    logic [CTRL_W-1:0]  w_main_ctrl_in;
    logic [DATA_W-1:0]  w_main_data;
    logic [DATA_W-1:0]  w_skid_data;
    logic [DATA_W-1:0]  w_main_data_in;

    assign w_out_valid = (r_state != EMPTY);
    assign w_in_ready  = SKID ? r_in_ready : (!w_out_valid || bus.out_ready);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_consume   = w_out_valid && bus.out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_skid_load      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = HALF;
                    w_main_load = 1'b1;
                end
            end
            HALF: begin
                if (w_accept && w_consume) begin
                    w_main_load = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = FULL;
                    w_skid_load = 1'b1;
                end else if (w_consume) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_consume) begin
                    w_state_nxt      = HALF;
                    w_main_load      = 1'b1;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        // Squash wins: nothing moves, and a same-cycle accept is dropped.
        if (flush) begin
            w_state_nxt      = EMPTY;
            w_main_load      = 1'b0;
            w_skid_load      = 1'b0;
            w_main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !bus.out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign w_main_ctrl_in = w_main_from_skid ? w_skid_ctrl : bus.in_ctrl;
    assign w_main_data_in = w_main_from_skid ? w_skid_data : bus.in_data;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_main_load),
        .i_clr   (flush),
        .i_ctrl  (w_main_ctrl_in),
        .i_data  (w_main_data_in),
        .o_ctrl  (w_main_ctrl),
        .o_data  (w_main_data)
    );

    generate
        if (SKID) begin : g_skid
            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk     (clk),
                .reset_n (reset_n),
                .i_load  (w_skid_load),
                .i_clr   (flush),
                .i_ctrl  (bus.in_ctrl),
                .i_data  (bus.in_data),
                .o_ctrl  (w_skid_ctrl),
                .o_data  (w_skid_data)
            );
        end else begin : g_no_skid
            assign w_skid_ctrl = '0;
            assign w_skid_data = '0;
        end
    endgenerate

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_ctrl  = w_out_valid ? w_main_ctrl : '0;
    assign bus.out_data  = w_main_data;
    assign occupancy     = r_state;
    assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a skid instance and a no-skid instance
// driven with hand-computed vectors.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;
    int   errors = 0;
    int   checks = 0;

    logic [1:0]  occ_a, occ_b;
    logic [15:0] stall_a, stall_b;

    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(5)) bus_a ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(5)) bus_b ();

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(5), .SKID(1'b1)) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .bus       (bus_a),
        .occupancy (occ_a),
        .stall_cnt (stall_a)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(5), .SKID(1'b0)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .bus       (bus_b),
        .occupancy (occ_b),
        .stall_cnt (stall_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [4:0] c, input logic [31:0] d, input logic r);
        bus_a.in_valid  = v;
        bus_a.in_ctrl   = c;
        bus_a.in_data   = d;
        bus_a.out_ready = r;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] c, input logic [31:0] d, input logic r);
        bus_b.in_valid  = v;
        bus_b.in_ctrl   = c;
        bus_b.in_data   = d;
        bus_b.out_ready = r;
    endtask

    initial begin
        reset_n = 1'b0;
        flush   = 1'b0;
        drive_a(1'b0, 5'h00, 32'h0, 1'b0);
        drive_b(1'b0, 5'h00, 32'h0, 1'b0);
        tick();
        tick();
        chk("rst_out_valid", 32'(bus_a.out_valid), 32'h0);
        chk("rst_out_ctrl",  32'(bus_a.out_ctrl),  32'h0);
        chk("rst_occ",       32'(occ_a),           32'h0);
        chk("rst_stall",     32'(stall_a),         32'h0);
        chk("rst_in_ready",  32'(bus_a.in_ready),  32'h1);
        reset_n = 1'b1;

        // Streaming at full rate: one-cycle latency, occupancy pinned at 1.
        for (int i = 1; i <= 8; i++) begin
            drive_a(1'b1, 5'(i), 32'(i), 1'b1);
            tick();
            chk("stream_valid", 32'(bus_a.out_valid), 32'h1);
            chk("stream_data",  bus_a.out_data,       32'(i));
            chk("stream_ctrl",  32'(bus_a.out_ctrl),  32'(i));
            chk("stream_occ",   32'(occ_a),           32'h1);
        end
        drive_a(1'b0, 5'h00, 32'h0, 1'b1);
        tick();
        chk("stream_drain_valid", 32'(bus_a.out_valid), 32'h0);
        chk("stream_drain_ctrl",  32'(bus_a.out_ctrl),  32'h0);

        // Skid fill under stall, then ordered drain.
        drive_a(1'b1, 5'(1 << CTRL_REGWRITE), 32'h9, 1'b0);
        tick();
        chk("skid_pred_data", bus_a.out_data,      32'h9);
        chk("skid_pred_ctrl", 32'(bus_a.out_ctrl), 32'h04);
        drive_a(1'b1, 5'h01, 32'hA, 1'b0);
        tick();
        chk("skid_full_ready", 32'(bus_a.in_ready), 32'h0);
        chk("skid_full_occ",   32'(occ_a),          32'h2);
        chk("skid_full_data",  bus_a.out_data,      32'h9);
        chk("skid_stall1",     32'(stall_a),        32'h1);
        drive_a(1'b1, 5'h02, 32'hB, 1'b0);
        tick();
        chk("skid_hold_occ",   32'(occ_a),          32'h2);
        chk("skid_hold_ready", 32'(bus_a.in_ready), 32'h0);
        chk("skid_hold_data",  bus_a.out_data,      32'h9);
        chk("skid_stall2",     32'(stall_a),        32'h2);
        drive_a(1'b1, 5'h02, 32'hB, 1'b1);
        tick();
        chk("skid_drain_a",     bus_a.out_data,      32'hA);
        chk("skid_drain_ctrl",  32'(bus_a.out_ctrl), 32'h01);
        chk("skid_drain_ready", 32'(bus_a.in_ready), 32'h1);
        chk("skid_drain_occ",   32'(occ_a),          32'h1);
        tick();
        chk("skid_drain_b",   bus_a.out_data,      32'hB);
        chk("skid_drain_occ2", 32'(occ_a),         32'h1);
        drive_a(1'b0, 5'h00, 32'h0, 1'b1);
        tick();
        chk("skid_empty",  32'(bus_a.out_valid), 32'h0);
        chk("skid_stall_final", 32'(stall_a),    32'h2);

        // Flush from FULL with a live offer in the same cycle.
        drive_a(1'b1, 5'(1 << CTRL_MEMREAD), 32'h11, 1'b0);
        tick();
        drive_a(1'b1, 5'h02, 32'h22, 1'b0);
        tick();
        chk("flush_pre_occ", 32'(occ_a), 32'h2);
        flush = 1'b1;
        drive_a(1'b1, 5'b11111, 32'h33, 1'b0);
        tick();
        flush = 1'b0;
        chk("flush_valid", 32'(bus_a.out_valid), 32'h0);
        chk("flush_ctrl",  32'(bus_a.out_ctrl),  32'h0);
        chk("flush_occ",   32'(occ_a),           32'h0);
        chk("flush_ready", 32'(bus_a.in_ready),  32'h1);
        chk("flush_stall", 32'(stall_a),         32'h4);
        drive_a(1'b0, 5'h00, 32'h0, 1'b1);
        tick();
        chk("flush_no_ghost", 32'(bus_a.out_valid), 32'h0);

        // Reset mid-stream while FULL, also overriding a concurrent flush.
        drive_a(1'b1, 5'h01, 32'h44, 1'b0);
        tick();
        drive_a(1'b1, 5'h02, 32'h55, 1'b0);
        tick();
        chk("rst2_pre_stall", 32'(stall_a), 32'h5);
        reset_n = 1'b0;
        flush   = 1'b1;
        drive_a(1'b1, 5'h1F, 32'h66, 1'b1);
        tick();
        reset_n = 1'b1;
        flush   = 1'b0;
        chk("rst2_valid", 32'(bus_a.out_valid), 32'h0);
        chk("rst2_ctrl",  32'(bus_a.out_ctrl),  32'h0);
        chk("rst2_occ",   32'(occ_a),           32'h0);
        chk("rst2_stall", 32'(stall_a),         32'h0);
        chk("rst2_ready", 32'(bus_a.in_ready),  32'h1);
        drive_a(1'b1, 5'((1 << CTRL_J) | (1 << CTRL_MEMWRITE)), 32'h77, 1'b1);
        tick();
        chk("rst2_new_valid", 32'(bus_a.out_valid), 32'h1);
        chk("rst2_new_data",  bus_a.out_data,       32'h77);
        chk("rst2_new_ctrl",  32'(bus_a.out_ctrl),  32'h0A);
        drive_a(1'b0, 5'h00, 32'h0, 1'b1);
        tick();

        // Long stall: counter saturates and holds.
        drive_a(1'b1, 5'h01, 32'h88, 1'b0);
        tick();
        chk("sat_start", 32'(stall_a), 32'h0);
        drive_a(1'b0, 5'h00, 32'h0, 1'b0);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", 32'(stall_a), 32'hFFFE);
        tick();
        chk("sat_ffff", 32'(stall_a), 32'hFFFF);
        repeat (2000) @(posedge clk);
        #1;
        chk("sat_hold", 32'(stall_a), 32'hFFFF);
        chk("sat_data", bus_a.out_data, 32'h88);
        drive_a(1'b0, 5'h00, 32'h0, 1'b1);
        tick();
        chk("sat_drain_valid", 32'(bus_a.out_valid), 32'h0);
        chk("sat_after_drain", 32'(stall_a),         32'hFFFF);

        // No-skid instance: combinational ready, same-cycle consume+accept.
        drive_b(1'b1, 5'(1 << CTRL_BR), 32'h5A, 1'b0);
        tick();
        chk("ns_valid", 32'(bus_b.out_valid), 32'h1);
        chk("ns_data",  bus_b.out_data,       32'h5A);
        chk("ns_ctrl",  32'(bus_b.out_ctrl),  32'h10);
        chk("ns_occ",   32'(occ_b),           32'h1);
        drive_b(1'b1, 5'h03, 32'h5B, 1'b0);
        #1;
        chk("ns_ready_low", 32'(bus_b.in_ready), 32'h0);
        tick();
        chk("ns_stall_data", bus_b.out_data, 32'h5A);
        chk("ns_stall_occ",  32'(occ_b),     32'h1);
        chk("ns_stall_cnt",  32'(stall_b),   32'h1);
        drive_b(1'b1, 5'h03, 32'h5B, 1'b1);
        #1;
        chk("ns_ready_high", 32'(bus_b.in_ready), 32'h1);
        tick();
        chk("ns_swap_data", bus_b.out_data,      32'h5B);
        chk("ns_swap_ctrl", 32'(bus_b.out_ctrl), 32'h03);
        chk("ns_swap_occ",  32'(occ_b),          32'h1);
        drive_b(1'b0, 5'h00, 32'h0, 1'b1);
        tick();
        chk("ns_empty_valid", 32'(bus_b.out_valid), 32'h0);
        chk("ns_empty_occ",   32'(occ_b),           32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
